// File: rtl/ref_period_meter_pkg.sv
// Shared types and constants for the reference period meter.
// The fractional width is shared with the downstream divider.
package ref_period_meter_pkg;

  localparam int FSZE      = 3;
  localparam int SAT_GUARD = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    UPD  = 2'd2
  } state_t;

endpackage

// File: rtl/ref_period_meter_if.sv
// Measurement bus between the reference pin logic and the divider.
// The meter is the slave; the stimulus/consumer side is the master.
interface ref_period_meter_if #(
  parameter int WIDTH = 17
);

  logic                    en;
  logic                    ref_in;
  logic [WIDTH-1:0]        n_nom;
  logic [WIDTH-1:0]        n_out;
  logic signed [WIDTH-1:0] mf_out;
  logic                    upd_stb;
  logic                    locked;
  logic                    tmo_stb;

  modport master (
    output en, ref_in, n_nom,
    input  n_out, mf_out, upd_stb, locked, tmo_stb
  );

  modport slave (
    input  en, ref_in, n_nom,
    output n_out, mf_out, upd_stb, locked, tmo_stb
  );

endinterface

// File: rtl/ref_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detect.
// Runs on the falling edge, like the divider it feeds.
module ref_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic edge_p
);

  logic [2:0] sh;

  always_ff @(negedge clk) begin
    if (rst) begin
      sh     <= '0;
      edge_p <= 1'b0;
    end else begin
      sh     <= {sh[1:0], d};
      edge_p <= sh[1] & ~sh[2];
    end
  end

endmodule

// File: rtl/ref_period_meter.sv
// Averages 8 reference periods and emits n_out + mf_out/8 divide settings.
// Define FRAC_MEAS_GLITCH_REJECT_EN to drop edges closer than MIN_PERIOD.
module ref_period_meter
  import ref_period_meter_pkg::*;
#(
  parameter int WIDTH      = 17,
  parameter int LOCK_TOL   = 4,
  parameter int MIN_PERIOD = 16
) (
  input logic               sys_clk,
  input logic               rst,
  ref_period_meter_if.slave bus
);

  localparam int AW = WIDTH + FSZE;
  localparam int DW = AW + SAT_GUARD;
  localparam logic [WIDTH-1:0] PMAX = '1;
  localparam logic [WIDTH-1:0] MINP = WIDTH'(MIN_PERIOD);
  localparam logic [AW-1:0]    TOL  = AW'(LOCK_TOL);
  localparam logic signed [DW-1:0] HI =
    {{(DW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [DW-1:0] LO =
    {{(DW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`ifdef FRAC_MEAS_GLITCH_REJECT_EN
  localparam bit REJ = 1'b1;
`else
  localparam bit REJ = 1'b0;
`endif

  state_t                  state;
  logic [WIDTH-1:0]        pcnt;
  logic [AW-1:0]           acc;
  logic [AW-1:0]           total;
  logic [2:0]              wcnt;
  logic                    prev_ok;
  logic                    edge_p;
  logic                    glitch;
  logic                    acc_ok;
  logic                    tmo;
  logic [AW-1:0]           tot;
  logic [AW-1:0]           absd;
  logic signed [DW-1:0]    diff;
  logic signed [WIDTH-1:0] mf_nxt;

  ref_edge_sync u_sync (
    .clk    (sys_clk),
    .rst    (rst),
    .d      (bus.ref_in),
    .edge_p (edge_p)
  );

  // The IDLE start edge has no meaningful period, so it is never rejected.
  assign glitch = REJ & (state != IDLE) & (pcnt < MINP);
  assign acc_ok = edge_p & ~glitch;
  assign tmo    = (state != IDLE) & (pcnt == PMAX) & ~edge_p;

  assign tot  = acc + {{FSZE{1'b0}}, pcnt};
  assign absd = (tot >= total) ? tot - total : total - tot;
  assign diff = $signed({2'b00, tot})
              - $signed({2'b00, bus.n_nom, {FSZE{1'b0}}});

  always_comb begin
    mf_nxt = diff[WIDTH-1:0];
    if (diff > HI)      mf_nxt = HI[WIDTH-1:0];
    else if (diff < LO) mf_nxt = LO[WIDTH-1:0];
  end

  always_ff @(negedge sys_clk) begin
    if (rst) begin
      state       <= IDLE;
      pcnt        <= '0;
      acc         <= '0;
      total       <= '0;
      wcnt        <= '0;
      prev_ok     <= 1'b0;
      bus.n_out   <= '0;
      bus.mf_out  <= '0;
      bus.upd_stb <= 1'b0;
      bus.locked  <= 1'b0;
      bus.tmo_stb <= 1'b0;
    end else begin
      bus.upd_stb <= 1'b0;
      bus.tmo_stb <= 1'b0;
      if (acc_ok)
        pcnt <= WIDTH'(1);
      else if (pcnt != PMAX)
        pcnt <= pcnt + WIDTH'(1);

      if (!bus.en) begin
        state      <= IDLE;
        bus.locked <= 1'b0;
      end else if (tmo) begin
        state       <= IDLE;
        bus.locked  <= 1'b0;
        bus.tmo_stb <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (acc_ok) begin
              state   <= MEAS;
              acc     <= '0;
              wcnt    <= '0;
              prev_ok <= 1'b0;
            end
          end
          MEAS, UPD: begin
            if (state == UPD)
              state <= MEAS;
            if (acc_ok) begin
              wcnt <= wcnt + 3'd1;
              if (wcnt == 3'd7) begin
                state       <= UPD;
                total       <= tot;
                acc         <= '0;
                prev_ok     <= 1'b1;
                bus.n_out   <= bus.n_nom;
                bus.mf_out  <= mf_nxt;
                bus.upd_stb <= 1'b1;
                bus.locked  <= prev_ok & (absd <= TOL);
              end else begin
                acc <= tot;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ref_period_meter.sv
// Directed and randomized checks of ref_period_meter against a
// window-level reference model of the averaged divide settings.
module tb_ref_period_meter;

  localparam int W    = 8;
  localparam int TOL  = 4;
  localparam int MINP = 16;
  localparam int PMX  = (1 << W) - 1;
  localparam int SHI  = (1 << (W - 1)) - 1;
  localparam int SLO  = -(1 << (W - 1));

  typedef struct {
    int n;
    int mf;
    int lk;
  } upd_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   ntmo   = 0;
  upd_t got[$];
  upd_t exp_q[$];

  always #5 clk = ~clk;

  ref_period_meter_if #(.WIDTH(W)) bus ();

  ref_period_meter #(
    .WIDTH      (W),
    .LOCK_TOL   (TOL),
    .MIN_PERIOD (MINP)
  ) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always @(posedge clk) begin
    if (bus.upd_stb)
      got.push_back('{int'(bus.n_out), int'($signed(bus.mf_out)),
                      int'(bus.locked)});
    if (bus.tmo_stb)
      ntmo <= ntmo + 1;
  end

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Window model: gaps between consecutive ref_in rises after the start
  // edge; rejected gaps merge into the following one.
  function automatic void model(input int n_nom, input int gaps[$]);
    int run = 0;
    int sum = 0;
    int k = 0;
    int prev = 0;
    int pv = 0;
    int d, mf, lk, p;
    foreach (gaps[i]) begin
      run += gaps[i];
`ifdef FRAC_MEAS_GLITCH_REJECT_EN
      if (run < MINP) continue;
`endif
      p = (run > PMX) ? PMX : run;
      run = 0;
      sum += p;
      k++;
      if (k == 8) begin
        d  = sum - 8 * n_nom;
        mf = (d > SHI) ? SHI : (d < SLO) ? SLO : d;
        lk = (pv != 0) && ((sum > prev ? sum - prev : prev - sum) <= TOL);
        exp_q.push_back('{n_nom, mf, lk});
        prev = sum;
        pv   = 1;
        sum  = 0;
        k    = 0;
      end
    end
  endfunction

  task automatic pulse();
    bus.ref_in = 1'b1;
    @(posedge clk);
    bus.ref_in = 1'b0;
  endtask

  task automatic send(input int gaps[$]);
    pulse();
    foreach (gaps[i]) begin
      repeat (gaps[i] - 1) @(posedge clk);
      pulse();
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_cnt"}, got.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got.size()) begin
        chk($sformatf("%s_n%0d", tag, i), got[i].n, exp_q[i].n);
        chk($sformatf("%s_mf%0d", tag, i), got[i].mf, exp_q[i].mf);
        chk($sformatf("%s_lk%0d", tag, i), got[i].lk, exp_q[i].lk);
      end
  endtask

  task automatic scen(input string tag, input int n_nom, input int gaps[$]);
    got.delete();
    exp_q.delete();
    bus.n_nom = W'(n_nom);
    bus.en    = 1'b1;
    @(posedge clk);
    model(n_nom, gaps);
    send(gaps);
    repeat (8) @(posedge clk);
    bus.en = 1'b0;
    repeat (4) @(posedge clk);
    compare(tag);
  endtask

  initial begin
    int g[$];
    int t, nt0;
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.ref_in = 1'b0;
    bus.n_nom  = '0;
    repeat (3) @(posedge clk);
    chk("rst_n_out", int'(bus.n_out), 0);
    chk("rst_mf_out", int'(bus.mf_out), 0);
    chk("rst_upd", int'(bus.upd_stb), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_tmo", int'(bus.tmo_stb), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    g.delete(); repeat (16) g.push_back(100);
    scen("clean", 100, g);
    g = '{101, 100, 101, 100, 101, 100, 100, 100};
    scen("plus3", 100, g);
    g.delete(); repeat (8) g.push_back(100);
    scen("minus8", 101, g);
    g.delete(); repeat (8) g.push_back(255);
    scen("sat_hi", 0, g);
    g.delete(); repeat (8) g.push_back(100);
    g.push_back(100); g.push_back(100);
    repeat (6) g.push_back(101);
    scen("tol_out", 100, g);
    g.delete(); repeat (4) g.push_back(100);
    repeat (4) g.push_back(101);
    scen("tol_edge", 100, g);
    g.delete(); repeat (16) begin g.push_back(5); g.push_back(95); end
    scen("glitch", 100, g);
    g.delete(); repeat (24) g.push_back(95 + $urandom_range(0, 10));
    scen("rand", 90 + $urandom_range(0, 20), g);

    got.delete();
    bus.n_nom = W'(100);
    bus.en    = 1'b1;
    @(posedge clk);
    g.delete(); repeat (4) g.push_back(100);
    send(g);
    bus.en = 1'b0;
    repeat (4) @(posedge clk);
    chk("en_drop_noupd", got.size(), 0);
    g.delete(); repeat (8) g.push_back(100);
    scen("after_en", 100, g);

    got.delete();
    exp_q.delete();
    bus.n_nom = W'(100);
    bus.en    = 1'b1;
    @(posedge clk);
    g.delete(); repeat (16) g.push_back(100);
    model(100, g);
    send(g);
    nt0 = ntmo;
    t = 1;
    while (bus.tmo_stb !== 1'b1 && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk("tmo_latency", t, 259);
    chk("tmo_locked", int'(bus.locked), 0);
    chk("tmo_n_hold", int'(bus.n_out), 100);
    chk("tmo_mf_hold", int'($signed(bus.mf_out)), 0);
    @(posedge clk);
    chk("tmo_one_pulse", int'(bus.tmo_stb), 0);
    chk("tmo_count", ntmo - nt0, 1);
    compare("pre_tmo");
    g.delete(); repeat (8) g.push_back(100);
    scen("post_tmo", 77, g);

    bus.n_nom = W'(101);
    bus.en    = 1'b1;
    @(posedge clk);
    g.delete(); repeat (3) g.push_back(100);
    send(g);
    rst = 1'b1;
    @(posedge clk);
    chk("mid_rst_n_out", int'(bus.n_out), 0);
    chk("mid_rst_mf_out", int'(bus.mf_out), 0);
    chk("mid_rst_upd", int'(bus.upd_stb), 0);
    chk("mid_rst_locked", int'(bus.locked), 0);
    chk("mid_rst_tmo", int'(bus.tmo_stb), 0);
    rst = 1'b0;
    bus.en = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
